// File: rtl/kernel_loader_if.sv
// Handshake, control and result bundle between a kernel source and kernel_loader.
// The master side issues loads and streams taps; the slave side is the loader.
interface kernel_loader_if #(
  parameter int KSIZE  = 7,
  parameter int COEF_W = 8
);

  localparam int N = KSIZE * KSIZE;

  logic                  start;
  logic [7:0]            div_in;
  logic [COEF_W-1:0]     coef_in;
  logic                  coef_valid;
  logic                  coef_ready;
  logic                  abort;
  logic [N*COEF_W-1:0]   kernel;
  logic [7:0]            divisor;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, div_in, coef_in, coef_valid, abort,
    input  coef_ready, kernel, divisor, busy, done, err
  );

  modport slave (
    input  start, div_in, coef_in, coef_valid, abort,
    output coef_ready, kernel, divisor, busy, done, err
  );

endinterface

// File: rtl/kernel_loader.sv
// Double-buffered convolution kernel loader: taps stream into a shadow copy and
// become active in one COMMIT cycle. Optional checksum word: KERNEL_LOADER_CHECKSUM_EN.
module kernel_loader #(
  parameter int KSIZE  = 7,
  parameter int COEF_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  kernel_loader_if.slave  bus
);

  localparam int N     = KSIZE * KSIZE;
  localparam int KW    = N * COEF_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

`ifdef KERNEL_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2, CHECK = 2'd3} stateType;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2} stateType;
`endif

  // Reset kernel is a pass-through: only the centre tap carries weight 1.
  function automatic logic [KW-1:0] identityKernel();
    logic [KW-1:0] k;
    k = '0;
    k[KW-1-(N/2)*COEF_W -: COEF_W] = COEF_W'(1);
    return k;
  endfunction

  stateType           state;
  logic [IDX_W-1:0]   tapIdx;
  logic [COEF_W-1:0]  shadowTap [N];
  logic [7:0]         shadowDiv;
  logic [KW-1:0]      kernelReg;
  logic [7:0]         divisorReg;
  logic               busyReg;
  logic               doneReg;
  logic               readyReg;
  logic               accept;

`ifdef KERNEL_LOADER_CHECKSUM_EN
  logic [COEF_W-1:0]  runSum;
  logic               errReg;
`endif

  assign accept = bus.coef_valid && readyReg;

  // One block owns the FSM, the shadow buffer and every registered output,
  // so ready/busy/done always line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tapIdx     <= '0;
      shadowDiv  <= '0;
      kernelReg  <= identityKernel();
      divisorReg <= 8'd1;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      readyReg   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shadowTap[i] <= '0;
      end
`ifdef KERNEL_LOADER_CHECKSUM_EN
      runSum     <= '0;
      errReg     <= 1'b0;
`endif
    end else begin
      doneReg <= 1'b0;
`ifdef KERNEL_LOADER_CHECKSUM_EN
      errReg  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            shadowDiv <= bus.div_in;
            tapIdx    <= '0;
            busyReg   <= 1'b1;
            readyReg  <= 1'b1;
            state     <= LOAD;
`ifdef KERNEL_LOADER_CHECKSUM_EN
            runSum    <= COEF_W'(bus.div_in);
`endif
          end
        end

        LOAD: begin
          if (bus.abort) begin
            busyReg  <= 1'b0;
            readyReg <= 1'b0;
            state    <= IDLE;
          end else if (accept) begin
            shadowTap[tapIdx] <= bus.coef_in;
            tapIdx            <= tapIdx + IDX_W'(1);
`ifdef KERNEL_LOADER_CHECKSUM_EN
            runSum            <= runSum + bus.coef_in;
            if (tapIdx == LAST_IDX) begin
              state <= CHECK;
            end
`else
            if (tapIdx == LAST_IDX) begin
              readyReg <= 1'b0;
              state    <= COMMIT;
            end
`endif
          end
        end

`ifdef KERNEL_LOADER_CHECKSUM_EN
        // The extra word must equal the running sum; a mismatch leaves the
        // active kernel untouched and only reports the error.
        CHECK: begin
          if (bus.abort) begin
            busyReg  <= 1'b0;
            readyReg <= 1'b0;
            state    <= IDLE;
          end else if (accept) begin
            readyReg <= 1'b0;
            if (bus.coef_in == runSum) begin
              state <= COMMIT;
            end else begin
              errReg  <= 1'b1;
              busyReg <= 1'b0;
              state   <= IDLE;
            end
          end
        end
`endif

        COMMIT: begin
          for (int i = 0; i < N; i++) begin
            kernelReg[KW-1-i*COEF_W -: COEF_W] <= shadowTap[i];
          end
          divisorReg <= (shadowDiv == 8'd0) ? 8'd1 : shadowDiv;
          doneReg    <= 1'b1;
          busyReg    <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          busyReg  <= 1'b0;
          readyReg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.coef_ready = readyReg;
  assign bus.kernel     = kernelReg;
  assign bus.divisor    = divisorReg;
  assign bus.busy       = busyReg;
  assign bus.done       = doneReg;
`ifdef KERNEL_LOADER_CHECKSUM_EN
  assign bus.err        = errReg;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_loader.sv
// Scoreboard bench for kernel_loader: loads push expected results, a negedge
// monitor pops them on done/err and also checks kernel stability in between.
module tb_kernel_loader;

  localparam int KSIZE  = 7;
  localparam int COEF_W = 8;
  localparam int N      = KSIZE * KSIZE;
  localparam int KW     = N * COEF_W;
`ifdef KERNEL_LOADER_CHECKSUM_EN
  localparam bit CSUM   = 1'b1;
`else
  localparam bit CSUM   = 1'b0;
`endif

  typedef struct {
    logic [KW-1:0] expKernel;
    logic [7:0]    expDiv;
    bit            expErr;
    int            expTaps;
    int            expLat;
    bit            checkLat;
  } sbEntry;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kernel_loader_if #(.KSIZE(KSIZE), .COEF_W(COEF_W)) bus ();

  kernel_loader #(.KSIZE(KSIZE), .COEF_W(COEF_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            checks = 0;
  int            errors = 0;
  int            cycle = 0;
  int            acceptCount = 0;
  int            nthCycle = 0;
  sbEntry        sbq [$];
  logic [COEF_W-1:0] stimTaps [N];
  logic [KW-1:0] activeKernel;
  logic [7:0]    activeDiv;
  logic [KW-1:0] identityK;

  task automatic checkOutput(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference view of the spec: tap i sits at the i-th COEF_W field from the MSB end.
  function automatic logic [KW-1:0] packTaps();
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < N; i++) k[KW-1-i*COEF_W -: COEF_W] = stimTaps[i];
    return k;
  endfunction

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.coef_valid && bus.coef_ready) begin
        acceptCount++;
        if (acceptCount == N) nthCycle = cycle;
      end
      if (bus.done || bus.err) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse actual done=%0b err=%0b required none", bus.done, bus.err);
        end else begin
          sbEntry e;
          e = sbq.pop_front();
          checkOutput("done_err", KW'({bus.done, bus.err}), KW'({~e.expErr, e.expErr}));
          checkOutput("kernel", bus.kernel, e.expKernel);
          checkOutput("divisor", KW'(bus.divisor), KW'(e.expDiv));
          checkOutput("tap_count", KW'(acceptCount), KW'(e.expTaps));
          if (e.checkLat) checkOutput("latency", KW'(cycle - nthCycle), KW'(e.expLat));
          if (!e.expErr) begin
            activeKernel = e.expKernel;
            activeDiv    = e.expDiv;
          end
        end
      end else begin
        checkOutput("kernel_stable", bus.kernel, activeKernel);
        checkOutput("divisor_stable", KW'(bus.divisor), KW'(activeDiv));
      end
      if (bus.start && !bus.busy) acceptCount = 0;
    end
  end

  // validMode: 0 held high, 1 toggling, 2 random. abortAfter < 0 means no abort.
  task automatic applyStimulus(input logic [7:0] divIn, input int validMode, input int abortAfter,
                               input bit noisyStart, input bit badSum);
    sbEntry e;
    int sent;
    int guard;
    int total;
    logic [COEF_W-1:0] sum;
    total = N + (CSUM ? 1 : 0);
    sum = COEF_W'(divIn);
    for (int i = 0; i < N; i++) sum = sum + stimTaps[i];
    if (badSum) sum = sum + COEF_W'(1);
    if (abortAfter < 0) begin
      e.expErr   = CSUM && badSum;
      e.expKernel = e.expErr ? activeKernel : packTaps();
      e.expDiv   = e.expErr ? activeDiv : ((divIn == 8'd0) ? 8'd1 : divIn);
      e.expTaps  = total;
      e.expLat   = CSUM ? 3 : 2;
      e.checkLat = !CSUM || (validMode == 0);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    bus.div_in = divIn;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.div_in = 8'($urandom);
    sent  = 0;
    guard = 0;
    while (sent < total && guard < 1000) begin
      if (abortAfter >= 0 && sent == abortAfter) begin
        bus.abort      = 1'b1;
        bus.coef_valid = 1'b1;
        bus.coef_in    = COEF_W'($urandom);
        @(posedge clk); #1;
        bus.abort      = 1'b0;
        bus.coef_valid = 1'b0;
        break;
      end
      case (validMode)
        0:       bus.coef_valid = 1'b1;
        1:       bus.coef_valid = (guard % 2) == 0;
        default: bus.coef_valid = 1'($urandom_range(0, 1));
      endcase
      bus.coef_in = (sent < N) ? stimTaps[sent] : sum;
      bus.start   = noisyStart && ($urandom_range(0, 2) == 0);
      bus.div_in  = 8'($urandom);
      @(negedge clk);
      if (bus.coef_valid && bus.coef_ready) sent++;
      @(posedge clk); #1;
      guard++;
    end
    bus.coef_valid = 1'b0;
    bus.start      = 1'b0;
    if (guard >= 1000) begin
      checks++;
      errors++;
      $display("[TB] FAIL stream_timeout actual sent=%0d required %0d", sent, total);
    end
    if (abortAfter >= 0) begin
      @(negedge clk);
      checkOutput("abort_busy", KW'(bus.busy), KW'(0));
      checkOutput("abort_ready", KW'(bus.coef_ready), KW'(0));
    end
    guard = 0;
    while (sbq.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout actual pending=%0d required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic fillGaussian();
    int g [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    int ctr = KSIZE / 2;
    for (int i = 0; i < N; i++) stimTaps[i] = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        stimTaps[(ctr - 1 + r) * KSIZE + (ctr - 1 + c)] = COEF_W'(g[r][c]);
  endtask

  task automatic fillConst(input logic [COEF_W-1:0] v);
    for (int i = 0; i < N; i++) stimTaps[i] = v;
  endtask

  task automatic fillRandom();
    for (int i = 0; i < N; i++) stimTaps[i] = COEF_W'($urandom);
  endtask

  task automatic checkResetState(input string tag);
    @(negedge clk);
    checkOutput({tag, "_kernel"}, bus.kernel, identityK);
    checkOutput({tag, "_centre_tap"}, KW'(bus.kernel[199:192]), KW'(8'h01));
    checkOutput({tag, "_divisor"}, KW'(bus.divisor), KW'(1));
    checkOutput({tag, "_busy"}, KW'(bus.busy), KW'(0));
    checkOutput({tag, "_ready"}, KW'(bus.coef_ready), KW'(0));
    checkOutput({tag, "_done_err"}, KW'({bus.done, bus.err}), KW'(0));
  endtask

  task automatic applyResetMidLoad();
    fillRandom();
    @(posedge clk); #1;
    bus.div_in = 8'd77;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.coef_valid = 1'b1;
      bus.coef_in    = stimTaps[i];
      @(posedge clk); #1;
    end
    bus.coef_valid = 1'b0;
    activeKernel = identityK;
    activeDiv    = 8'd1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkResetState("midload_reset");
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.div_in     = '0;
    bus.coef_in    = '0;
    bus.coef_valid = 1'b0;
    bus.abort      = 1'b0;
    identityK      = '0;
    identityK[KW-1-(N/2)*COEF_W -: COEF_W] = COEF_W'(1);
    activeKernel   = identityK;
    activeDiv      = 8'd1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkResetState("reset");

    fillGaussian();
    applyStimulus(8'd16, 0, -1, 1'b0, 1'b0);
    fillGaussian();
    applyStimulus(8'd16, 1, -1, 1'b0, 1'b0);

    fillRandom();
    applyStimulus(8'd33, 0, 20, 1'b0, 1'b0);
    fillConst(COEF_W'(1));
    applyStimulus(8'd49, 0, -1, 1'b0, 1'b0);

    fillConst(COEF_W'(8'hFF));
    applyStimulus(8'd0, 0, -1, 1'b1, 1'b0);

    applyResetMidLoad();

    for (int k = 0; k < 8; k++) begin
      int ab;
      logic [7:0] dv;
      fillRandom();
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      dv = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      applyStimulus(dv, int'($urandom_range(0, 2)), ab, 1'($urandom_range(0, 1)),
                    CSUM && ($urandom_range(0, 1) == 1));
    end

    if (CSUM) begin
      fillGaussian();
      applyStimulus(8'd16, 0, -1, 1'b0, 1'b0);
      fillConst(COEF_W'(3));
      applyStimulus(8'd9, 0, -1, 1'b0, 1'b1);
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_empty", KW'(sbq.size()), KW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_loader.md
KERNEL_LOADER -- requirements
Module: kernel_loader

Interface
REQ-001 The block SHALL have parameter KSIZE, default 7, kernel edge length; N = KSIZE*KSIZE taps.
REQ-002 The block SHALL have parameter COEF_W, default 8, coefficient width in bits (two's complement).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new kernel load.
REQ-006 The block SHALL have port div_in, input, 8 bits: unsigned divisor, sampled on the accepted start.
REQ-007 The block SHALL have port coef_in, input, COEF_W bits: coefficient stream, row-major order, top-left first.
REQ-008 The block SHALL have port coef_valid, input, 1 bit: coef_in holds a valid coefficient.
REQ-009 The block SHALL have port coef_ready, output, 1 bit: the block accepts a coefficient this cycle.
REQ-010 The block SHALL have port abort, input, 1 bit: cancel the load in progress.
REQ-011 The block SHALL have port kernel, output, N*COEF_W bits: active kernel; tap i at bits [N*COEF_W-1-i*COEF_W -: COEF_W].
REQ-012 The block SHALL have port divisor, output, 8 bits: active divisor.
REQ-013 The block SHALL have port busy, output, 1 bit: high in LOAD and COMMIT.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse when a new kernel becomes active.
REQ-015 The block SHALL have port err, output, 1 bit: one-cycle pulse on a rejected load (checksum builds only; constant 0 otherwise).

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, (CHECK, with macro only), COMMIT.
REQ-017 In IDLE, start=1 SHALL capture div_in into a shadow divisor, clear tap index to 0, and enter LOAD; start outside IDLE SHALL be ignored.
REQ-018 coef_ready SHALL be 1 only in LOAD (and CHECK); a coefficient is accepted when coef_valid && coef_ready.
REQ-019 Each accepted coefficient SHALL be written to shadow tap[index], and index SHALL increment by 1.
REQ-020 Acceptance with index = N-1 SHALL transition to COMMIT (or to CHECK with macro) on the same edge.
REQ-021 COMMIT SHALL last exactly one cycle: copy shadow taps and shadow divisor to kernel/divisor, assert done, then return to IDLE.
REQ-022 A captured divisor of 0 SHALL be replaced by 1 at commit.
REQ-023 kernel and divisor SHALL change only in COMMIT or on reset; they remain stable throughout LOAD.
REQ-024 abort=1 in LOAD or CHECK SHALL return to IDLE on the next edge without changing kernel/divisor; a coefficient presented in the same cycle SHALL be discarded.
REQ-025 abort in IDLE or COMMIT SHALL have no effect; COMMIT always completes.
REQ-026 Latency from the last accepted coefficient to the updated kernel output SHALL be 2 cycles without macro (1 cycle for the edge into COMMIT, 1 cycle for COMMIT), 3 with macro.

Reset
REQ-027 Reset SHALL force IDLE, index 0, busy=0, done=0, err=0, and coef_ready=0.
REQ-028 Reset SHALL load kernel as identity: centre tap (i = N/2) = 1, all other taps = 0, and divisor = 1.
REQ-029 Reset asserted mid-load SHALL discard the shadow contents and restore the identity kernel.

Configuration
REQ-030 When KERNEL_LOADER_CHECKSUM_EN is defined, the block SHALL keep a modulo-2^COEF_W running sum of accepted taps and div_in.
REQ-031 With the macro defined, after the Nth tap the block SHALL accept one extra checksum word in CHECK.
REQ-032 With the macro defined, a matching checksum SHALL go to COMMIT, and a mismatch SHALL pulse err, keep the active kernel, and return to IDLE.
REQ-033 Without the macro, CHECK SHALL not exist, err SHALL be tied to 0, and no extra word is consumed.

Verification
REQ-034 Reset release -> kernel has 8'h01 at bits [199:192], all else 0; divisor = 1; busy = 0.
REQ-035 start with div_in=16, then 49 taps of the 3x3 Gaussian pattern (1,2,1 / 2,4,2 / 1,2,1 centred, rest 0) with coef_valid held high -> done pulses 2 cycles after the last tap; kernel matches; divisor = 16.
REQ-036 Same load with coef_valid toggling every other cycle -> identical final kernel; exactly 49 taps are accepted.
REQ-037 abort after 20 taps, then a full 7x7 box load (all 8'h01, div_in=49) -> intermediate kernel unchanged; final kernel all ones with divisor 49.
REQ-038 div_in=0 with 49 taps of 8'hFF -> divisor = 1, all taps 8'hFF; start pulses during busy are ignored.
REQ-039 Macro build: correct checksum -> done; checksum off by 1 -> err pulse, kernel unchanged.
